// File: rtl/uart_pkg.sv
// Shared types and helpers for the oversampling UART receiver.
//   parity_mode_t : parity selection (none / even / odd)
//   rx_state_t    : receiver FSM state encoding plus its state constants
//   rx_status_t   : per-word status flags stored alongside the data in the RX FIFO
//   calc_div      : clock cycles per oversample tick
package uart_pkg;

  typedef enum logic [1:0] {
    PARITY_NONE = 2'd0,
    PARITY_EVEN = 2'd1,
    PARITY_ODD  = 2'd2
  } parity_mode_t;

  typedef logic [2:0] rx_state_t;

  localparam rx_state_t RX_IDLE     = 3'd0;
  localparam rx_state_t RX_START    = 3'd1;
  localparam rx_state_t RX_DATA     = 3'd2;
  localparam rx_state_t RX_PARITY   = 3'd3;
  localparam rx_state_t RX_STOP     = 3'd4;
  localparam rx_state_t RX_BRK_WAIT = 3'd5;

  typedef struct packed {
    logic brk;
    logic frame_err;
    logic parity_err;
  } rx_status_t;

  // Integer division: any remainder shows up as a small bit-rate error.
  function automatic int unsigned calc_div(input int unsigned clk_hz,
                                           input int unsigned bit_rate,
                                           input int unsigned ovs);
    return clk_hz / (bit_rate * ovs);
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Synchronous FIFO with registered storage; the head entry drives rdata directly
// (no fall-through, a pushed word becomes visible the cycle after the push).
//   clk, resetn : clock, synchronous active-low reset (pointers and storage cleared)
//   push, wdata : write request and data; accepted when not full or when popping
//   pop         : remove head entry; ignored when empty
//   rdata       : head entry
//   full, empty : occupancy flags
module uart_rx_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  // One extra pointer bit distinguishes full from empty.
  logic [AW:0]      wr_q, rd_q;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  always_comb begin
    empty   = (wr_q == rd_q);
    full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    do_pop  = pop && !empty;
    // When full, a same-cycle pop frees the slot being written.
    do_push = push && (!full || do_pop);
    rdata   = mem_q[rd_q[AW-1:0]];
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_q <= '0;
      rd_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem_q[wr_q[AW-1:0]] <= wdata;
        wr_q                <= wr_q + 1'b1;
      end
      if (do_pop) begin
        rd_q <= rd_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_rx_ovs.sv
// Oversampling UART receiver with 3-sample majority voting, parity/framing/break
// status per word and an RX FIFO behind a valid/ready interface.
//   clk, resetn    : clock, synchronous active-low reset
//   uart_rxd       : asynchronous serial input (idle high)
//   uart_rx_en     : receive enable; low aborts any frame in progress
//   rx_data        : head word data
//   rx_parity_err  : head word parity error
//   rx_frame_err   : head word framing error
//   rx_break       : head word is a BREAK
//   rx_valid       : FIFO non-empty
//   rx_ready       : head popped when rx_valid && rx_ready
//   overflow       : sticky, set when a word is dropped on a full FIFO
//   overflow_clr   : clears overflow (a same-cycle set wins)
//   rx_busy        : receiver FSM not idle
module uart_rx_ovs
  import uart_pkg::*;
#(
  parameter int unsigned CLK_HZ       = 50_000_000,
  parameter int unsigned BIT_RATE     = 115200,
  parameter int unsigned OVERSAMPLE   = 16,
  parameter int unsigned PAYLOAD_BITS = 8,
  parameter int unsigned PARITY_MODE  = 0,
  parameter int unsigned STOP_BITS    = 1,
  parameter int unsigned FIFO_DEPTH   = 8
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    uart_rxd,
  input  logic                    uart_rx_en,
  output logic [PAYLOAD_BITS-1:0] rx_data,
  output logic                    rx_parity_err,
  output logic                    rx_frame_err,
  output logic                    rx_break,
  output logic                    rx_valid,
  input  logic                    rx_ready,
  output logic                    overflow,
  input  logic                    overflow_clr,
  output logic                    rx_busy
);

  localparam int unsigned DIV     = calc_div(CLK_HZ, BIT_RATE, OVERSAMPLE);
  localparam int unsigned DIV_W   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned SCNT_W  = $clog2(OVERSAMPLE);
  localparam int unsigned BIT_W   = $clog2(PAYLOAD_BITS);
  localparam int unsigned ENTRY_W = PAYLOAD_BITS + 3;

  localparam bit HAS_PARITY = (PARITY_MODE != int'(PARITY_NONE));
  localparam bit ODD_PARITY = (PARITY_MODE == int'(PARITY_ODD));

  localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(DIV - 1);
  localparam logic [SCNT_W-1:0] SMP_A    = SCNT_W'(OVERSAMPLE / 2 - 1);
  localparam logic [SCNT_W-1:0] SMP_B    = SCNT_W'(OVERSAMPLE / 2);
  localparam logic [SCNT_W-1:0] SMP_C    = SCNT_W'(OVERSAMPLE / 2 + 1);
  localparam logic [SCNT_W-1:0] SCNT_END = SCNT_W'(OVERSAMPLE - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST = BIT_W'(PAYLOAD_BITS - 1);
  localparam logic              STOP_LST = 1'(STOP_BITS - 1);

  // Parameter legality, checked at elaboration.
  if (OVERSAMPLE < 8 || (OVERSAMPLE % 2) != 0) begin : g_bad_ovs
    $error("OVERSAMPLE must be even and >= 8");
  end
  if (PAYLOAD_BITS < 5 || PAYLOAD_BITS > 9) begin : g_bad_payload
    $error("PAYLOAD_BITS must be in 5..9");
  end
  if (PARITY_MODE > 2) begin : g_bad_parity
    $error("PARITY_MODE must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
    $error("STOP_BITS must be 1 or 2");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("FIFO_DEPTH must be a power of 2 and >= 2");
  end
  if (DIV < 1) begin : g_bad_div
    $error("CLK_HZ too low for BIT_RATE * OVERSAMPLE");
  end

  // State
  logic [1:0]              sync_q;
  rx_state_t               state_q, state_d;
  logic [DIV_W-1:0]        div_q, div_d;
  logic [SCNT_W-1:0]       scnt_q, scnt_d;
  logic [BIT_W-1:0]        bit_q, bit_d;
  logic                    stop_q, stop_d;
  logic                    smp_a_q, smp_a_d, smp_b_q, smp_b_d;
  logic [PAYLOAD_BITS-1:0] data_q, data_d;
  logic                    pbit_q, pbit_d;
  rx_status_t              st_q, st_d;
  logic                    overflow_q, overflow_d;

  logic                    rxs, tick, decide, bit_end, maj;
  logic                    push;
  rx_status_t              push_st;
  logic [ENTRY_W-1:0]      push_word, head;
  logic                    fifo_full, fifo_empty, pop;

  assign rxs = sync_q[1];

  // Two-flop synchroniser; frozen while the receiver is disabled.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      sync_q <= 2'b11;
    end else if (uart_rx_en) begin
      sync_q <= {sync_q[0], uart_rxd};
    end
  end

  always_comb begin
    tick    = (state_q != RX_IDLE) && (div_q == DIV_LAST);
    decide  = tick && (scnt_q == SMP_C);
    bit_end = tick && (scnt_q == SCNT_END);
    // Third sample is the live synchronised input at the decision tick.
    maj     = (smp_a_q & smp_b_q) | (smp_a_q & rxs) | (smp_b_q & rxs);
  end

  always_comb begin
    state_d   = state_q;
    div_d     = div_q;
    scnt_d    = scnt_q;
    bit_d     = bit_q;
    stop_d    = stop_q;
    smp_a_d   = smp_a_q;
    smp_b_d   = smp_b_q;
    data_d    = data_q;
    pbit_d    = pbit_q;
    st_d      = st_q;
    push      = 1'b0;
    push_st   = st_q;

    // Tick and sample counters only run inside a frame.
    if (state_q == RX_IDLE) begin
      div_d  = '0;
      scnt_d = '0;
    end else begin
      div_d = tick ? '0 : div_q + 1'b1;
      if (tick) begin
        scnt_d = (scnt_q == SCNT_END) ? '0 : scnt_q + 1'b1;
        if (scnt_q == SMP_A) smp_a_d = rxs;
        if (scnt_q == SMP_B) smp_b_d = rxs;
      end
    end

    case (state_q)
      RX_IDLE: begin
        if (!rxs) begin
          state_d = RX_START;
          bit_d   = '0;
          stop_d  = 1'b0;
          pbit_d  = 1'b0;
          st_d    = '0;
        end
      end
      RX_START: begin
        if (decide && maj) begin
          state_d = RX_IDLE;  // false start
        end else if (bit_end) begin
          state_d = RX_DATA;
        end
      end
      RX_DATA: begin
        if (decide) data_d = {maj, data_q[PAYLOAD_BITS-1:1]};
        if (bit_end) begin
          if (bit_q == BIT_LAST) begin
            state_d = HAS_PARITY ? RX_PARITY : RX_STOP;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      RX_PARITY: begin
        if (decide) begin
          pbit_d          = maj;
          st_d.parity_err = ((^data_q) ^ maj) != ODD_PARITY;
        end
        if (bit_end) state_d = RX_STOP;
      end
      RX_STOP: begin
        if (decide) begin
          push_st.frame_err = st_q.frame_err | ~maj;
          // Break: everything after the start bit, up to the first stop bit, was low.
          push_st.brk       = st_q.brk | (!stop_q && (data_q == '0) &&
                                          !(HAS_PARITY && pbit_q) && !maj);
          st_d              = push_st;
          if (stop_q == STOP_LST) begin
            push    = 1'b1;
            // Leave half a bit early so the next start edge is not missed.
            state_d = push_st.brk ? RX_BRK_WAIT : RX_IDLE;
          end
        end else if (bit_end) begin
          stop_d = 1'b1;
        end
      end
      RX_BRK_WAIT: begin
        if (rxs) state_d = RX_IDLE;
      end
      default: state_d = RX_IDLE;
    endcase

    if (!uart_rx_en) begin
      state_d = RX_IDLE;
      push    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= RX_IDLE;
      div_q   <= '0;
      scnt_q  <= '0;
      bit_q   <= '0;
      stop_q  <= 1'b0;
      smp_a_q <= 1'b1;
      smp_b_q <= 1'b1;
      data_q  <= '0;
      pbit_q  <= 1'b0;
      st_q    <= '0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      scnt_q  <= scnt_d;
      bit_q   <= bit_d;
      stop_q  <= stop_d;
      smp_a_q <= smp_a_d;
      smp_b_q <= smp_b_d;
      data_q  <= data_d;
      pbit_q  <= pbit_d;
      st_q    <= st_d;
    end
  end

  assign push_word = {push_st, data_q};
  assign pop       = !fifo_empty && rx_ready;

  uart_rx_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .resetn (resetn),
    .push   (push),
    .wdata  (push_word),
    .pop    (pop),
    .rdata  (head),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

  // Set wins over clear.
  assign overflow_d = (push && fifo_full && !pop) | (overflow_q & ~overflow_clr);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      overflow_q <= 1'b0;
    end else begin
      overflow_q <= overflow_d;
    end
  end

  assign rx_data       = head[PAYLOAD_BITS-1:0];
  assign rx_parity_err = head[PAYLOAD_BITS];
  assign rx_frame_err  = head[PAYLOAD_BITS+1];
  assign rx_break      = head[PAYLOAD_BITS+2];
  assign rx_valid      = !fifo_empty;
  assign overflow      = overflow_q;
  assign rx_busy       = (state_q != RX_IDLE);

endmodule

// File: tb/tb_uart_rx_ovs.sv
// Self-checking bench for uart_rx_ovs: 8E1, one clock per oversample tick, 4-deep FIFO.
// A frame-level model predicts each FIFO entry and the overflow flag; one negedge process
// compares the DUT head/valid/overflow against it every cycle.
module tb_uart_rx_ovs;

  localparam int DEPTH    = 4;
  localparam int BIT_CLKS = 16;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       uart_rxd = 1'b1;
  logic       uart_rx_en = 1'b0;
  logic       rx_ready = 1'b0;
  logic       overflow_clr = 1'b0;
  logic [7:0] rx_data;
  logic       rx_parity_err, rx_frame_err, rx_break, rx_valid, overflow, rx_busy;

  int         n_cmp = 0;
  int         n_err = 0;
  logic [10:0] exp_q[$];
  logic [10:0] pop_log[$];
  logic        exp_ovf = 1'b0;
  bit          chk_en = 1'b0;

  always #5 clk = ~clk;

  uart_rx_ovs #(
    .CLK_HZ       (1_843_200),
    .BIT_RATE     (115200),
    .OVERSAMPLE   (16),
    .PAYLOAD_BITS (8),
    .PARITY_MODE  (1),
    .STOP_BITS    (1),
    .FIFO_DEPTH   (DEPTH)
  ) u_dut (
    .clk           (clk),
    .resetn        (resetn),
    .uart_rxd      (uart_rxd),
    .uart_rx_en    (uart_rx_en),
    .rx_data       (rx_data),
    .rx_parity_err (rx_parity_err),
    .rx_frame_err  (rx_frame_err),
    .rx_break      (rx_break),
    .rx_valid      (rx_valid),
    .rx_ready      (rx_ready),
    .overflow      (overflow),
    .overflow_clr  (overflow_clr),
    .rx_busy       (rx_busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      if (n_err <= 40) $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Entry = {break, frame_err, parity_err, data}; even parity over data plus parity bit.
  function automatic logic [10:0] model_entry(input logic [7:0] d, input logic pbit,
                                              input logic stop_v);
    logic pe, fe, brk;
    pe  = ((($countones(d) + int'(pbit)) % 2) != 0);
    fe  = (stop_v == 1'b0);
    brk = (d == 8'h00) && !pbit && !stop_v;
    return {brk, fe, pe, d};
  endfunction

  task automatic model_push(input logic [7:0] d, input logic pbit, input logic stop_v);
    if (exp_q.size() >= DEPTH) exp_ovf = 1'b1;
    else exp_q.push_back(model_entry(d, pbit, stop_v));
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Called #1 after a posedge. Start bit is on the line before edge E0; the stop-bit vote
  // lands in the cycle after E171, so the entry is in the FIFO from E172 onwards.
  task automatic send_frame(input logic [7:0] d, input logic pbit, input logic stop_v,
                            input bit release_line);
    logic [10:0] bits;
    bits = {stop_v, pbit, d, 1'b0};
    for (int n = 0; n < 11; n++) begin
      uart_rxd = bits[n];
      if (n == 10) begin
        idle(13);
        model_push(d, pbit, stop_v);
        idle(BIT_CLKS - 13);
      end else begin
        idle(BIT_CLKS);
      end
    end
    if (release_line) uart_rxd = 1'b1;
  endtask

  always @(negedge clk) begin
    if (chk_en && resetn) begin
      chk("rx_valid", {31'd0, rx_valid}, {31'd0, exp_q.size() != 0});
      chk("overflow", {31'd0, overflow}, {31'd0, exp_ovf});
      if (exp_q.size() != 0) begin
        chk("head", {21'd0, rx_break, rx_frame_err, rx_parity_err, rx_data},
            {21'd0, exp_q[0]});
        if (rx_ready && rx_valid) begin
          pop_log.push_back({rx_break, rx_frame_err, rx_parity_err, rx_data});
          void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    logic [10:0] exp_log [10];
    bit          saw_busy;

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst rx_data", {24'd0, rx_data}, 32'd0);
    chk("rst rx_parity_err", {31'd0, rx_parity_err}, 32'd0);
    chk("rst rx_frame_err", {31'd0, rx_frame_err}, 32'd0);
    chk("rst rx_break", {31'd0, rx_break}, 32'd0);
    chk("rst rx_valid", {31'd0, rx_valid}, 32'd0);
    chk("rst overflow", {31'd0, overflow}, 32'd0);
    chk("rst rx_busy", {31'd0, rx_busy}, 32'd0);
    @(posedge clk); #1;
    resetn = 1'b1;
    uart_rx_en = 1'b1;
    rx_ready = 1'b1;
    idle(4);
    chk_en = 1'b1;

    // Clean word
    send_frame(8'hA5, 1'b0, 1'b1, 1'b1);
    idle(32);

    // Parity error, then the same data with correct parity
    send_frame(8'h03, 1'b1, 1'b1, 1'b1);
    idle(32);
    send_frame(8'h03, 1'b0, 1'b1, 1'b1);
    idle(32);

    // Framing error, then a clean frame
    send_frame(8'h5A, 1'b0, 1'b0, 1'b1);
    idle(48);
    send_frame(8'h11, 1'b0, 1'b1, 1'b1);
    idle(32);

    // Break: line low for 20 bit-times
    send_frame(8'h00, 1'b0, 1'b0, 1'b0);
    idle(20 * BIT_CLKS - 11 * BIT_CLKS);
    chk("break wait busy", {31'd0, rx_busy}, 32'd1);
    uart_rxd = 1'b1;
    idle(8);
    chk("break released busy", {31'd0, rx_busy}, 32'd0);
    idle(16);

    // Three-tick low glitch: false start, no entry
    uart_rxd = 1'b0;
    idle(3);
    uart_rxd = 1'b1;
    saw_busy = 1'b0;
    for (int i = 0; i < 30; i++) begin
      idle(1);
      if (rx_busy) saw_busy = 1'b1;
    end
    chk("glitch busy pulse", {31'd0, saw_busy}, 32'd1);
    chk("glitch back idle", {31'd0, rx_busy}, 32'd0);

    // Disable mid-frame: frame dropped, FSM idle
    uart_rxd = 1'b0;
    idle(24);
    uart_rxd = 1'b1;
    idle(8);
    uart_rx_en = 1'b0;
    idle(2);
    chk("disable idle", {31'd0, rx_busy}, 32'd0);
    idle(20);
    uart_rx_en = 1'b1;
    idle(40);
    chk("reenable idle", {31'd0, rx_busy}, 32'd0);

    // Overflow: five words into a 4-deep FIFO with no consumer
    rx_ready = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      send_frame(8'(i), ^(8'(i)), 1'b1, 1'b1);
      idle(16);
    end
    chk("overflow set", {31'd0, overflow}, 32'd1);
    rx_ready = 1'b1;
    idle(8);
    overflow_clr = 1'b1;
    idle(1);
    exp_ovf = 1'b0;
    overflow_clr = 1'b0;
    idle(4);
    chk("overflow cleared", {31'd0, overflow}, 32'd0);

    // Reset mid-frame with a word held in the FIFO
    rx_ready = 1'b0;
    send_frame(8'h42, 1'b0, 1'b1, 1'b1);
    idle(8);
    uart_rxd = 1'b0;
    idle(20);
    resetn = 1'b0;
    exp_q.delete();
    idle(1);
    chk("midreset rx_valid", {31'd0, rx_valid}, 32'd0);
    chk("midreset rx_busy", {31'd0, rx_busy}, 32'd0);
    chk("midreset rx_data", {24'd0, rx_data}, 32'd0);
    uart_rxd = 1'b1;
    resetn = 1'b1;
    idle(8);
    chk("post reset busy", {31'd0, rx_busy}, 32'd0);
    chk("post reset valid", {31'd0, rx_valid}, 32'd0);

    // Hand-computed sequence of words consumed
    exp_log = '{11'h0A5, 11'h103, 11'h003, 11'h25A, 11'h011,
                11'h600, 11'h001, 11'h002, 11'h003, 11'h004};
    chk("popped count", pop_log.size(), 32'd10);
    for (int i = 0; i < 10; i++) begin
      if (i < pop_log.size()) chk($sformatf("popped[%0d]", i), {21'd0, pop_log[i]},
                                  {21'd0, exp_log[i]});
    end

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/uart_rx_ovs.md
Name: uart_rx_ovs

Overview:
Parametrised oversampling UART receiver, the successor to the fixed 8N1 receiver.
- Configurable payload width, parity and stop bits.
- Samples each bit with a 3-sample majority vote; rejects false start bits.
- Reports parity, framing and break status per word; buffers words in a small RX FIFO behind a valid/ready stream interface.
- Sits between the pad-side uart_rxd pin and the system bus/register interface.

Parameters:
CLK_HZ, 50_000_000, system clock frequency in Hz
BIT_RATE, 115200, line bit rate
OVERSAMPLE, 16, sample ticks per bit; even, ≥8
PAYLOAD_BITS, 8, data bits per frame, 5..9
PARITY_MODE, 0, 0=none, 1=even, 2=odd
STOP_BITS, 1, 1 or 2
FIFO_DEPTH, 8, RX FIFO entries; power of 2, ≥2

Ports:
clk  in  1  system clock
resetn  in  1  synchronous active-low reset
uart_rxd  in  1  asynchronous serial input
uart_rx_en  in  1  receive enable
rx_data  out  PAYLOAD_BITS  FIFO head data
rx_parity_err  out  1  head word parity error
rx_frame_err  out  1  head word framing error (stop bit 0)
rx_break  out  1  head word is a BREAK
rx_valid  out  1  FIFO non-empty
rx_ready  in  1  consumer pops head when rx_valid && rx_ready
overflow  out  1  sticky: word dropped because FIFO full
overflow_clr  in  1  clears overflow
rx_busy  out  1  FSM not in IDLE

Behaviour:
- Reset is synchronous, active-low (resetn); clock clk.
- Reset values: rx_data, rx_parity_err, rx_frame_err, rx_break, rx_valid, overflow, rx_busy = 0. Synchroniser flops = 1. FSM = IDLE. FIFO empty.
- Synchronisation: 2-flop synchroniser on uart_rxd, producing rxs.
- Tick generator: DIV = CLK_HZ/(BIT_RATE*OVERSAMPLE), integer division. Counter 0..DIV-1 pulses tick at wrap. It runs only outside IDLE and is reset to 0 on leaving IDLE.
- Sample counter: scnt counts 0..OVERSAMPLE-1 per bit on tick.
- Bit sampling: rxs is sampled at scnt = OVERSAMPLE/2-1, OVERSAMPLE/2 and OVERSAMPLE/2+1. The bit value is the majority of the three, decided at OVERSAMPLE/2+1.
- FSM states: IDLE, START, DATA, PARITY, STOP, BRK_WAIT.
  - IDLE: rxs==0 && uart_rx_en → START.
  - START: majority==1 → IDLE (false start, nothing pushed). Otherwise, at bit end → DATA.
  - DATA: shifts in LSB first. After PAYLOAD_BITS bits → PARITY if PARITY_MODE≠0, else STOP.
  - PARITY: parity_err = (XOR of data ^ sampled bit) != (PARITY_MODE==2).
  - STOP: each of the STOP_BITS stop bits is voted. Any 0 sets frame_err. At the majority decision of the last stop bit, the word is pushed and the FSM goes → IDLE (half-bit early exit, to resync). If break was detected, it goes → BRK_WAIT instead.
  - BRK_WAIT: waits for rxs==1, then → IDLE. No push occurs in this state.
- Break detection: data==0, the parity bit (if present) ==0, and the first stop bit ==0. The word is pushed with rx_break=1 and frame_err=1. Exactly one entry is pushed per break, whatever its duration.
- Enable deassertion: uart_rx_en=0 forces the FSM to IDLE on the next cycle. The partial frame is discarded and FIFO contents are retained. While disabled, the synchroniser holds its value.
- FIFO entry: {break, frame_err, parity_err, data}. Outputs come directly from the head entry; the FIFO is registered, with no fall-through.
  - A push into an empty FIFO gives rx_valid=1 on the next cycle.
  - Total latency is 1 clk from the last-stop-bit decision to rx_valid.
- Full FIFO:
  - A push while full without a same-cycle pop drops the new word and sets overflow. Existing contents are unchanged.
  - A push while full with a same-cycle pop is accepted.
- overflow: set has priority over overflow_clr in the same cycle.
- Pointers: log2(FIFO_DEPTH)+1 bits, wrap naturally. full = MSBs differ and LSBs equal.
- Reset mid-frame: everything returns to reset values on the next edge, including the FIFO.

Decomposition:
- Package uart_pkg:
  - parity_mode_t enum (NONE, EVEN, ODD)
  - rx_state_t enum (the six states)
  - rx_status_t packed struct (break, frame_err, parity_err)
  - function for the divisor computation
- Sub-module uart_rx_fifo: synchronous FIFO, parameters WIDTH and DEPTH, push/pop/full/empty. Reusable by a future TX buffer.
- Elaboration-time assertions check the legal parameter ranges and DIV ≥ 1.

Test Plan:
- CLK_HZ=1_843_200, BIT_RATE=115200 (DIV=1), 8N1. Send 0xA5, rx_ready=1 → one word 0xA5, all flags 0, rx_valid high 1 clk after last-stop decision.
- PARITY_MODE=1. Send 0x03 with parity bit 1 → rx_data=0x03, rx_parity_err=1. Same frame with parity 0 → rx_parity_err=0.
- Send 0x5A with stop bit 0, line back high afterwards → rx_frame_err=1, rx_break=0. The next frame 0x11 is received cleanly.
- Hold line low for 20 bit-times → exactly one entry: data 0x00, rx_break=1, rx_frame_err=1, FSM in BRK_WAIT until the line rises.
- Low glitch of 3 sample ticks while idle → FSM returns to IDLE from START, no entry, rx_busy pulses.
- FIFO_DEPTH=4, rx_ready=0, send 0x01..0x05 → 4 entries, overflow=1, 0x05 lost. Pop gives 0x01..0x04 in order. overflow_clr then clears overflow.
